// File: rtl/sd_stripe_route_sel.sv
// Routes one block of words from a selected SD read channel to the SRAM write path,
// rebuilding a failed channel as the XOR of the survivors (RAID5 degraded mode).
module sd_stripe_route_sel #(
    parameter int DATA_W        = 32,
    parameter int NUM_SD        = 3,
    parameter int ID_W          = 2,
    parameter int BLOCK_WORDS   = 128,
    parameter int FALLBACK_LAST = 1
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     map_load,
    input  logic [NUM_SD*ID_W-1:0]   map_in,
    input  logic                     start,
    input  logic [ID_W-1:0]          sel_id,
    input  logic [NUM_SD-1:0]        fail_mask,
    input  logic [NUM_SD*DATA_W-1:0] sd_data,
    input  logic [NUM_SD-1:0]        sd_valid,
    output logic [NUM_SD-1:0]        sd_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     degraded,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state, state_nxt;
    logic [NUM_SD*ID_W-1:0]   map_q, map_eff;
    logic [NUM_SD-1:0]        contrib_q, src_onehot, lookup_mask;
    logic                     found, src_failed, multi_fail, lookup_err;
    logic                     start_ok, start_bad;
    logic [CNT_W-1:0]         beat_cnt;
    logic                     last_taken;
    logic                     all_valid, can_load, consume, out_xfer, block_end;
    logic [DATA_W-1:0]        xor_word;

    // A map_load in the same idle cycle as start must be visible to that start's lookup.
    assign map_eff = (map_load && state == IDLE) ? map_in : map_q;

    always_comb begin
        found                  = 1'b0;
        src_onehot             = '0;
        src_onehot[NUM_SD-1]   = 1'b1;
        for (int k = NUM_SD - 1; k >= 0; k--) begin
            if (map_eff[k*ID_W +: ID_W] == sel_id) begin
                found         = 1'b1;
                src_onehot    = '0;
                src_onehot[k] = 1'b1;
            end
        end
        src_failed  = |(src_onehot & fail_mask);
        multi_fail  = |(fail_mask & (fail_mask - NUM_SD'(1)));
        lookup_mask = src_failed ? ~fail_mask : src_onehot;
        lookup_err  = (!found && (FALLBACK_LAST == 0)) ||
                      (src_failed && (multi_fail || (~fail_mask == '0)));
    end

    assign start_ok  = (state == IDLE) && start && !lookup_err;
    assign start_bad = (state == IDLE) && start && lookup_err;

    // Consume only when every contributor is valid together and the output slot frees up.
    assign all_valid = &(sd_valid | ~contrib_q);
    assign can_load  = !out_valid || out_ready;
    assign consume   = (state == RUN) && !last_taken && all_valid && can_load;
    assign sd_ready  = consume ? contrib_q : '0;
    assign out_xfer  = out_valid && out_ready;
    assign block_end = (state == RUN) && out_xfer && out_last;
    assign busy      = (state == RUN);

    always_comb begin
        xor_word = '0;
        for (int k = 0; k < NUM_SD; k++) begin
            if (contrib_q[k]) xor_word ^= sd_data[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)  state_nxt = RUN;
            RUN:     if (block_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            map_q      <= '0;
            contrib_q  <= '0;
            degraded   <= 1'b0;
            beat_cnt   <= '0;
            last_taken <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= block_end;
            err  <= start_bad;
            if (map_load && state == IDLE) map_q <= map_in;
            if (start_ok) begin
                contrib_q <= lookup_mask;
                degraded  <= src_failed;
            end else if (block_end) begin
                contrib_q <= '0;
                degraded  <= 1'b0;
            end
            // last_taken stops a following block's first beat from slipping in before block end.
            if (consume) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
                if (beat_cnt == LAST_BEAT) last_taken <= 1'b1;
            end else if (block_end) begin
                last_taken <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (consume) begin
            out_data  <= xor_word;
            out_valid <= 1'b1;
            out_last  <= (beat_cnt == LAST_BEAT);
        end else if (out_xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sd_stripe_route_sel.sv
// Table-driven bench for sd_stripe_route_sel with a scoreboard queue of expected words;
// a second instance with FALLBACK_LAST=0 covers the no-match error.
module tb_sd_stripe_route_sel;

    localparam int DW = 32;
    localparam int NS = 3;
    localparam int IW = 2;
    localparam int BW = 4;
    localparam logic [5:0] MAP0 = {2'd1, 2'd0, 2'd2};
    localparam logic [5:0] MAP1 = {2'd2, 2'd1, 2'd0};

    typedef struct {
        string       name;
        logic        do_load;
        logic [5:0]  map;
        logic [1:0]  sel;
        logic [2:0]  fail;
        logic [31:0] base [3];
        logic [2:0]  valid0;
        logic        exp_err;
        logic        exp_deg;
        logic [2:0]  exp_mask;
        int          hold;
        int          bp;
        logic        inject;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              n_rst, map_load, start, start_b, out_ready;
    logic [NS*IW-1:0]  map_in;
    logic [IW-1:0]     sel_id;
    logic [NS-1:0]     fail_mask, feed_valid, sd_ready, sd_ready_b;
    logic [NS*DW-1:0]  sd_data;
    logic [DW-1:0]     out_data, out_data_b;
    logic              out_valid, out_last, degraded, busy, done, err;
    logic              out_valid_b, out_last_b, degraded_b, busy_b, done_b, err_b;

    logic [DW-1:0]     cur_base [NS];
    logic [1:0]        feed_idx;
    logic [2:0]        exp_mask;
    exp_t              exp_q [$];
    vec_t              vecs [$];
    int                num_vec = 0;
    int                num_fail = 0;

    assign sd_data = {cur_base[2] + DW'(feed_idx), cur_base[1] + DW'(feed_idx),
                      cur_base[0] + DW'(feed_idx)};

    sd_stripe_route_sel #(.DATA_W(DW), .NUM_SD(NS), .ID_W(IW), .BLOCK_WORDS(BW),
                          .FALLBACK_LAST(1)) dut (
        .clk(clk), .n_rst(n_rst), .map_load(map_load), .map_in(map_in), .start(start),
        .sel_id(sel_id), .fail_mask(fail_mask), .sd_data(sd_data), .sd_valid(feed_valid),
        .sd_ready(sd_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .degraded(degraded), .busy(busy),
        .done(done), .err(err));

    sd_stripe_route_sel #(.DATA_W(DW), .NUM_SD(NS), .ID_W(IW), .BLOCK_WORDS(BW),
                          .FALLBACK_LAST(0)) dut_b (
        .clk(clk), .n_rst(n_rst), .map_load(map_load), .map_in(map_in), .start(start_b),
        .sel_id(sel_id), .fail_mask(fail_mask), .sd_data(sd_data), .sd_valid(feed_valid),
        .sd_ready(sd_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_last(out_last_b), .degraded(degraded_b),
        .busy(busy_b), .done(done_b), .err(err_b));

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        num_vec++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic addVec(input string name, input logic do_load, input logic [5:0] map,
                          input logic [1:0] sel, input logic [2:0] fail,
                          input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                          input logic [2:0] valid0, input logic exp_err, input logic exp_deg,
                          input logic [2:0] mask, input int hold, input int bp,
                          input logic inject);
        vec_t v;
        v.name = name; v.do_load = do_load; v.map = map; v.sel = sel; v.fail = fail;
        v.base[0] = b0; v.base[1] = b1; v.base[2] = b2; v.valid0 = valid0;
        v.exp_err = exp_err; v.exp_deg = exp_deg; v.exp_mask = mask;
        v.hold = hold; v.bp = bp; v.inject = inject;
        vecs.push_back(v);
    endtask

    // Sets up the channel feed, queues the block's expected words and pulses start.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        for (int k = 0; k < NS; k++) cur_base[k] = v.base[k];
        feed_idx   = 2'd0;
        feed_valid = v.valid0;
        exp_mask   = v.exp_mask;
        out_ready  = 1'b1;
        if (!v.exp_err) begin
            for (int b = 0; b < BW; b++) begin
                e.data = '0;
                for (int k = 0; k < NS; k++)
                    if (v.exp_mask[k]) e.data ^= v.base[k] + 32'(b);
                e.last = (b == BW - 1);
                exp_q.push_back(e);
            end
        end
        map_load  = v.do_load;
        map_in    = v.map;
        sel_id    = v.sel;
        fail_mask = v.fail;
        start     = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        map_load = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1; break; end
        end
        checkOutput({name, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            checkOutput({name, "_busy_at_done"}, 64'(busy), 64'd0);
            checkOutput({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
            @(posedge clk); #1;
            checkOutput({name, "_done_pulse"}, 64'(done), 64'd0);
        end
        exp_q.delete();
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(v);
        checkOutput({v.name, "_err"}, 64'(err), 64'(v.exp_err));
        checkOutput({v.name, "_busy"}, 64'(busy), 64'(!v.exp_err));
        checkOutput({v.name, "_degraded"}, 64'(degraded), 64'(v.exp_deg));
        if (v.exp_err) begin
            @(posedge clk); #1;
            checkOutput({v.name, "_err_pulse"}, 64'(err), 64'd0);
            checkOutput({v.name, "_idle"}, 64'(busy), 64'd0);
            return;
        end
        if (v.hold > 0) begin
            for (int i = 0; i < v.hold; i++) begin
                checkOutput({v.name, "_hold_ready"}, 64'(sd_ready), 64'd0);
                checkOutput({v.name, "_hold_valid"}, 64'(out_valid), 64'd0);
                @(posedge clk); #1;
            end
            feed_valid = 3'b111;
        end else begin
            checkOutput({v.name, "_first_ready"}, 64'(sd_ready), 64'(v.exp_mask));
            @(posedge clk); #1;
            checkOutput({v.name, "_latency"}, 64'(out_valid), 64'd1);
        end
        if (v.inject) begin
            map_load = 1'b1; map_in = 6'b111111; sel_id = 2'd3; fail_mask = 3'b111;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; map_load = 1'b0;
            checkOutput({v.name, "_busy_start_err"}, 64'(err), 64'd0);
            checkOutput({v.name, "_busy_kept"}, 64'(busy), 64'd1);
        end
        if (v.bp > 0) begin
            logic [31:0] held;
            for (int c = 0; c < 20 && !out_valid; c++) begin @(posedge clk); #1; end
            out_ready = 1'b0;
            held = out_data;
            for (int i = 0; i < v.bp; i++) begin
                @(posedge clk); #1;
                checkOutput({v.name, "_bp_data"}, 64'(out_data), 64'(held));
                checkOutput({v.name, "_bp_valid"}, 64'(out_valid), 64'd1);
            end
            out_ready = 1'b1;
        end
        waitDone(v.name);
    endtask

    // Scoreboard side: pops on each output transfer and advances the feed on each consumed beat.
    initial begin
        exp_t e;
        bit took;
        forever begin
            @(negedge clk);
            took = 0;
            if (n_rst) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        num_vec++; num_fail++;
                        $display("[TB] FAIL unexpected_word: got %0h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("out_data", 64'(out_data), 64'(e.data));
                        checkOutput("out_last", 64'(out_last), 64'(e.last));
                    end
                end
                if (out_valid && !out_ready)
                    checkOutput("stall_ready", 64'(sd_ready), 64'd0);
                if (|sd_ready) begin
                    checkOutput("ready_mask", 64'(sd_ready), 64'(exp_mask));
                    took = 1;
                end
            end
            @(posedge clk); #1;
            if (took && n_rst) feed_idx = feed_idx + 2'd1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_rst = 1'b0; map_load = 1'b0; start = 1'b0; start_b = 1'b0; out_ready = 1'b1;
        map_in = '0; sel_id = '0; fail_mask = '0; feed_valid = '0; feed_idx = '0;
        exp_mask = '0;
        for (int k = 0; k < NS; k++) cur_base[k] = '0;

        addVec("normal",   1, MAP0, 2'd0, 3'b000, 32'h1000_0000, 32'h1, 32'h2000_0000,
               3'b111, 0, 0, 3'b010, 0, 0, 0);
        addVec("inject",   0, MAP0, 2'd2, 3'b000, 32'h0000_0100, 32'h2, 32'h3,
               3'b111, 0, 0, 3'b001, 0, 0, 1);
        addVec("map_kept", 0, MAP0, 2'd0, 3'b000, 32'h7, 32'h0000_0040, 32'h9,
               3'b111, 0, 0, 3'b010, 0, 3, 0);
        addVec("fallback", 0, MAP0, 2'd3, 3'b000, 32'h11, 32'h22, 32'h0000_3300,
               3'b111, 0, 0, 3'b100, 0, 0, 0);
        addVec("degraded", 0, MAP0, 2'd0, 3'b010, 32'hA5A5_0000, 32'h1234, 32'h0000_5A5A,
               3'b011, 0, 1, 3'b101, 3, 0, 0);
        addVec("unrecov1", 0, MAP0, 2'd0, 3'b011, 32'h1, 32'h2, 32'h3,
               3'b111, 1, 0, 3'b000, 0, 0, 0);
        addVec("other_fail", 0, MAP0, 2'd0, 3'b001, 32'h5, 32'hBEEF_0000, 32'h6,
               3'b111, 0, 0, 3'b010, 0, 0, 0);
        addVec("degraded2", 0, MAP0, 2'd1, 3'b100, 32'h0F0F_0F0F, 32'h00FF_00F0, 32'h8,
               3'b111, 0, 1, 3'b011, 0, 3, 0);
        addVec("unrecov2", 0, MAP0, 2'd2, 3'b101, 32'h1, 32'h2, 32'h3,
               3'b111, 1, 0, 3'b000, 0, 0, 0);
        addVec("load_start", 1, MAP1, 2'd0, 3'b000, 32'h0000_0A00, 32'hB, 32'hC,
               3'b111, 0, 0, 3'b001, 0, 0, 0);
        addVec("new_map",  0, MAP1, 2'd2, 3'b000, 32'hD, 32'hE, 32'h0F00_0000,
               3'b111, 0, 0, 3'b100, 0, 0, 0);

        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done_err", 64'({done, err, degraded, out_last}), 64'd0);
        checkOutput("rst_sd_ready", 64'(sd_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) runVector(vecs[i]);

        // No-match error on the instance without fallback; shared map is MAP1 here.
        sel_id = 2'd3; fail_mask = 3'b000; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        checkOutput("nomatch_err", 64'(err_b), 64'd1);
        checkOutput("nomatch_busy", 64'(busy_b), 64'd0);
        @(posedge clk); #1;
        checkOutput("nomatch_err_pulse", 64'(err_b), 64'd0);

        // Asynchronous reset while a word is sitting in the output register.
        applyStimulus(vecs[0]);
        @(posedge clk); #1;
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_sd_ready", 64'(sd_ready), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        checkOutput("reset_no_done", 64'(done), 64'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        runVector(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_fail);
        $finish;
    end

endmodule
